// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide unit.
// The interface also carries the unit's FSM state for observation.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  // start is a request strobe: the unit accepts it on a rising edge when busy==0.
  // While busy==1 a request is dropped, not queued. done pulses for one cycle when
  // hi/lo first show a result. op/a/b only need to be valid in the accepting cycle.
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       state;

  modport master (output start, op, a, b, input busy, done, hi, lo, state);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, state);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide.
// Optional HILO_FAST_MULT_EN: single-cycle MULT/MULTU product; DIV stays iterative.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  hilo_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               is_mul;
  logic               neg_lo;
  logic               neg_hi;
  logic               dz_pending;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [2*WIDTH-1:0] p_fix;

  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg     = signed_op & bus.a[WIDTH-1];
  assign b_neg     = signed_op & bus.b[WIDTH-1];
  assign mag_a     = a_neg ? -bus.a : bus.a;
  assign mag_b     = b_neg ? -bus.b : bus.b;

  // Multiply: acc = {partial, multiplier}; add multiplicand on the low bit, shift right.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  // Divide: acc = {remainder, dividend/quotient}; shift left one and trial-subtract.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};

  assign q_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign p_fix = neg_lo ? -acc : acc;

`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  logic [2*WIDTH-1:0] fast_q;
  logic               fast_pending;

  assign fast_prod = signed_op
    ? ({{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b})
    : ({{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b});
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      acc        <= '0;
      opnd       <= '0;
      is_mul     <= 1'b0;
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
      dz_pending <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
`ifdef HILO_FAST_MULT_EN
      fast_q       <= '0;
      fast_pending <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      dz_pending <= 1'b0;
      if (dz_pending) done_q <= 1'b1;
`ifdef HILO_FAST_MULT_EN
      fast_pending <= 1'b0;
      // Placed before the FSM so an MTHI/MTLO accepted in this same cycle wins.
      if (fast_pending) begin
        {hi_q, lo_q} <= fast_q;
        done_q       <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MULT, OP_MULTU: begin
`ifdef HILO_FAST_MULT_EN
                fast_q       <= fast_prod;
                fast_pending <= 1'b1;
`else
                acc    <= {{WIDTH{1'b0}}, mag_b};
                opnd   <= mag_a;
                is_mul <= 1'b1;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg ^ b_neg;
                count  <= '0;
                busy_q <= 1'b1;
                state  <= MUL;
`endif
              end
              OP_DIV, OP_DIVU: begin
                if (bus.b == '0) begin
                  dz_pending <= 1'b1;
                end else begin
                  acc    <= {{WIDTH{1'b0}}, mag_a};
                  opnd   <= mag_b;
                  is_mul <= 1'b0;
                  neg_lo <= a_neg ^ b_neg;
                  neg_hi <= a_neg;
                  count  <= '0;
                  busy_q <= 1'b1;
                  state  <= DIV;
                end
              end
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          if (count == LAST) state <= FIX;
          else count <= count + 1'b1;
        end
        DIV: begin
          if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          else acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          if (count == LAST) state <= FIX;
          else count <= count + 1'b1;
        end
        FIX: begin
          if (is_mul) begin
            {hi_q, lo_q} <= p_fix;
          end else begin
            lo_q <= q_fix;
            hi_q <= r_fix;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          count  <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = state;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: spec vector table, multi-cycle corner sequences and
// randomized operations checked against an arithmetic HI/LO model.
module tb_hilo_muldiv_unit;
  localparam int W = 32;
`ifdef HILO_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;
  localparam int WIN     = 40;

  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  hilo_muldiv_unit_if #(.WIDTH(W)) bus ();
  hilo_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    int           exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
  task automatic model_apply(input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, output int lat);
    longint sq;
    longint sr;
    logic [63:0] p;
    lat = -1;
    case (op)
      MULT: begin
        sq = longint'($signed(a)) * longint'($signed(b));
        p = sq;
        {m_hi, m_lo} = p;
        lat = MUL_LAT;
      end
      MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = p;
        lat = MUL_LAT;
      end
      DIV, DIVU: begin
        if (b == 0) lat = 1;
        else begin
          if (op == DIV) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            m_lo = sq[W-1:0];
            m_hi = sr[W-1:0];
          end else begin
            m_lo = a / b;
            m_hi = a % b;
          end
          lat = DIV_LAT;
        end
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // driver: present a request for exactly one rising edge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = NOP;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Watch edges k=0..WIN after acceptance; kind 1 injects MTLO start, kind 2 a reset.
  task automatic observe(input int snap_k, input int inj_k, input int inj_kind,
                         output int lat, output bit extra, output bit busy_seen,
                         output logic [W-1:0] s_hi, output logic [W-1:0] s_lo,
                         output logic end_busy);
    lat = -1; extra = 0; busy_seen = 0; s_hi = 'x; s_lo = 'x;
    for (int k = 0; k <= WIN; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      reset = 1'b0;
      if (bus.done) begin
        if (lat < 0) lat = k;
        else extra = 1;
      end
      if (bus.busy) busy_seen = 1;
      if (k == snap_k) begin s_hi = bus.hi; s_lo = bus.lo; end
      if (k == inj_k && inj_kind == 1) begin
        bus.start = 1'b1; bus.op = MTLO; bus.a = 32'h0000FFFF;
      end
      if (k == inj_k && inj_kind == 2) reset = 1'b1;
    end
    end_busy = bus.busy;
  endtask

  task automatic run_check(input string name, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo, input int exp_lat);
    int lat; bit extra; bit bsy; logic [W-1:0] h; logic [W-1:0] l; logic eb;
    issue(op, a, b);
    observe((exp_lat < 0) ? 0 : exp_lat, -1, 0, lat, extra, bsy, h, l, eb);
    check({name, "_done_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_done_width"}, 64'(extra), 64'd0);
    check({name, "_busy_seen"}, 64'(bsy), 64'(exp_lat > 1));
    check({name, "_hi"}, 64'(h), 64'(exp_hi));
    check({name, "_lo"}, 64'(l), 64'(exp_lo));
  endtask

  vec_t vecs[$];

  initial begin
    int lat; bit extra; bit bsy; logic [W-1:0] h; logic [W-1:0] l; logic eb;
    int mlat; bit found;
    logic [2:0] rop; logic [W-1:0] ra; logic [W-1:0] rb;

    checks = 0; errors = 0;
    m_hi = '0; m_lo = '0;
    bus.start = 1'b0; bus.op = NOP; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);

    vecs.push_back('{"multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT});
    vecs.push_back('{"mult_neg",  MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT});
    vecs.push_back('{"div_neg",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT});
    vecs.push_back('{"divu_100_7",DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT});
    vecs.push_back('{"div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DIV_LAT});
    vecs.push_back('{"mthi_1234", MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'h80000000, -1});
    vecs.push_back('{"mtlo_5678", MTLO,  32'h00005678, 32'd9,        32'h00001234, 32'h00005678, -1});
    vecs.push_back('{"divu_zero", DIVU,  32'd55,       32'd0,        32'h00001234, 32'h00005678, 1});
    vecs.push_back('{"div_zero",  DIV,   32'hFFFFFFF0, 32'd0,        32'h00001234, 32'h00005678, 1});
    vecs.push_back('{"nop",       NOP,   32'h11111111, 32'd3,        32'h00001234, 32'h00005678, -1});
    vecs.push_back('{"op7",       3'd7,  32'h22222222, 32'd3,        32'h00001234, 32'h00005678, -1});
    vecs.push_back('{"mthi_cafe", MTHI,  32'hCAFEF00D, 32'd0,        32'hCAFEF00D, 32'h00005678, -1});
    vecs.push_back('{"mtlo_bad",  MTLO,  32'h0BADBEEF, 32'd0,        32'hCAFEF00D, 32'h0BADBEEF, -1});
    vecs.push_back('{"mult_min",  MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT});
    vecs.push_back('{"div_remneg",DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       DIV_LAT});

    foreach (vecs[i]) begin
      model_apply(vecs[i].op, vecs[i].a, vecs[i].b, mlat);
      run_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_lat);
    end

    // start re-asserted mid-divide must be dropped
    issue(DIVU, 32'd1000, 32'd7);
    observe(DIV_LAT, 5, 1, lat, extra, bsy, h, l, eb);
    check("ignore_done_lat", 64'(lat), 64'(DIV_LAT));
    check("ignore_hi", 64'(h), 64'd6);
    check("ignore_lo", 64'(l), 64'd142);
    m_hi = 32'd6; m_lo = 32'd142;

    // start accepted in the done cycle
    issue(DIVU, 32'd100, 32'd7);
    found = 0;
    for (int k = 0; k <= WIN && !found; k++) begin
      @(negedge clk);
      if (bus.done) found = 1;
    end
    check("b2b_first_done", 64'(found), 64'd1);
    check("b2b_first_lo", 64'(bus.lo), 64'd14);
    bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd5; bus.b = 32'd6;
    @(posedge clk);
    #1 bus.start = 1'b0;
    observe(MUL_LAT, -1, 0, lat, extra, bsy, h, l, eb);
    check("b2b_second_lat", 64'(lat), 64'(MUL_LAT));
    check("b2b_second_hi", 64'(h), 64'd0);
    check("b2b_second_lo", 64'(l), 64'd30);
    m_hi = 32'd0; m_lo = 32'd30;

    // reset at cycle 10 of a divide
    issue(DIV, 32'hFFFFFF9C, 32'd3);
    observe(12, 10, 2, lat, extra, bsy, h, l, eb);
    check("rst_mid_done", 64'(lat), -64'sd1);
    check("rst_mid_busy", 64'(eb), 64'd0);
    check("rst_mid_hi", 64'(h), 64'd0);
    check("rst_mid_lo", 64'(l), 64'd0);
    m_hi = '0; m_lo = '0;

    // randomized operations against the model
    for (int n = 0; n < 120; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      model_apply(rop, ra, rb, mlat);
      run_check($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, m_hi, m_lo, mlat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
